// File: rtl/latch_stim_tx_if.sv
// Handshake and latch-side signal bundle for latch_stim_tx.
// The producer uses the master modport; the serializer uses the slave modport.
interface latch_stim_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             abort;
  logic             D;
  logic             enable;
  logic             busy;
  logic             done;

  modport master (
    output tx_data, tx_valid, abort,
    input  tx_ready, D, enable, busy, done
  );

  modport slave (
    input  tx_data, tx_valid, abort,
    output tx_ready, D, enable, busy, done
  );
endinterface

// File: rtl/latch_stim_tx.sv
// Serializes a parallel word onto D with an enable strobe that is high only
// in the second half of each bit, so a gated latch chain captures stable data.
//
// state   | meaning
// IDLE    | waiting for tx_valid; tx_ready high, D/enable low
// SHIFT   | driving bits, BIT_CYCLES cycles each
// GAP     | one-cycle done pulse before returning to IDLE
module latch_stim_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic              clock,
  input  logic              reset,
  latch_stim_tx_if.slave    stim
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(BIT_CYCLES / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic [CW-1:0]    r_cyc_cnt;
  logic             r_d;
  logic             r_enable;
  logic             r_done;

  logic [WIDTH-1:0] w_shift_next;
  logic [CW-1:0]    w_cyc_inc;

  function automatic logic head_bit(input logic [WIDTH-1:0] x);
    return (MSB_FIRST != 0) ? x[WIDTH-1] : x[0];
  endfunction

  assign w_shift_next = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
  assign w_cyc_inc    = r_cyc_cnt + 1'b1;

  // D and enable are registered from the next-state decision so they line
  // up with the counters of the cycle they describe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cyc_cnt <= '0;
      r_d       <= 1'b0;
      r_enable  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_d      <= 1'b0;
          r_enable <= 1'b0;
          if (stim.tx_valid && !stim.abort) begin
            r_state   <= S_SHIFT;
            r_shift   <= stim.tx_data;
            r_bit_cnt <= '0;
            r_cyc_cnt <= '0;
            r_d       <= head_bit(stim.tx_data);
          end
        end
        S_SHIFT: begin
          if (stim.abort) begin
            r_state  <= S_IDLE;
            r_d      <= 1'b0;
            r_enable <= 1'b0;
          end else if (r_cyc_cnt == CYC_LAST) begin
            r_cyc_cnt <= '0;
            r_enable  <= 1'b0;
            r_shift   <= w_shift_next;
            if (r_bit_cnt == BIT_LAST) begin
              r_state   <= S_GAP;
              r_bit_cnt <= '0;
              r_d       <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_d       <= head_bit(w_shift_next);
            end
          end else begin
            r_cyc_cnt <= w_cyc_inc;
            r_enable  <= (w_cyc_inc >= CYC_HALF);
          end
        end
        S_GAP: begin
          r_state  <= S_IDLE;
          r_d      <= 1'b0;
          r_enable <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_d      <= 1'b0;
          r_enable <= 1'b0;
        end
      endcase
    end
  end

  assign stim.tx_ready = (r_state == S_IDLE);
  assign stim.busy     = (r_state == S_SHIFT) || (r_state == S_GAP);
  assign stim.D        = r_d;
  assign stim.enable   = r_enable;
  assign stim.done     = r_done;

endmodule
